timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped timer/counter peripheral on the CPU data bus, downstream of the core's data-memory port.
- The system bridge decodes its address window and forwards word accesses to it.
- Provides a down-counter with one-shot and auto-reload modes.
- Its irq output feeds the core's external interrupt input, the same input the bench drives as interrupt.

Parameters:
- WIDTH, 32, width of the PRESET and COUNT registers; must be in the range 2..32.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  2  word offset, equal to bus address bits [3:2]. 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  word write strobe, sampled on the rising clk edge.
- din  input  32  write data.
- dout  output  32  read data, combinational from addr.
- irq  output  1  interrupt request, level, active-high.

Behaviour:
- Registers
  - CTRL: bits [3:0] writable. Bit 0 is EN, bits [2:1] are MODE, bit 3 is IM (interrupt mask). Bits [31:4] read as 0.
  - PRESET: WIDTH bits, read/write.
  - COUNT: WIDTH bits, read-only.
  - Reads zero-extend to 32 bits. Offset 3 reads as 0; writes to offset 3 are ignored.
- Modes: MODE=01 is auto-reload. Any other MODE value (00, 10, 11) is one-shot.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, so irq=0 and dout reflects the reset registers.
- FSM, all transitions on the rising clk edge:
  - IDLE: if EN=1, go to LOAD; otherwise stay in IDLE.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT, first matching rule applies:
    - If EN=0, go to IDLE with COUNT held.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 0 or 1): COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - One-shot: EN<=0, go to IDLE.
    - Auto-reload: irq_flag<=0, go to IDLE. Because EN is still 1, the sequence continues IDLE->LOAD->CNT and the period repeats.
- irq = IM & irq_flag.
  - Auto-reload: irq is high for exactly one cycle per period, while the state is INT.
  - One-shot: irq_flag stays 1 until any write to CTRL or PRESET, or reset.
- Latency: let the CTRL write with EN=1 land on edge E0, with PRESET=N≥1.
  - LOAD is reached at E1.
  - COUNT=N at E2.
  - COUNT=1 at E(N+1).
  - INT is entered and irq rises at E(N+2).
  - Auto-reload period is N+3 cycles.
  - PRESET=0 behaves like PRESET=1: irq at E3.
- Simultaneous events:
  - A bus write to CTRL wins over the FSM's EN clear in INT during the same cycle.
  - A CTRL or PRESET write in the same cycle that irq_flag would be set clears it; the write wins.
  - A PRESET write while in CNT does not disturb the running COUNT; the new value takes effect at the next LOAD.
  - Clearing EN mid-count freezes COUNT. Re-enabling reloads from PRESET; there is no resume.
  - Changing MODE while in CNT takes effect when INT is entered.
- Reset asserted in any state returns everything to reset values on the next edge, including mid-INT and mid-count.

Optional Feature:
- Macro: TIMER_COUNT_WRITE_EN.
- When defined: a write to offset 2 loads COUNT<=din[WIDTH-1:0] at that edge, overriding the FSM's COUNT update that cycle. The state is unaffected. In CNT the next decrement uses the written value. A written 0 or 1 enters INT at the following edge.
- When undefined: writes to offset 2 are ignored and COUNT is read-only.

Test Plan:
- Reset then read offsets 0..3 -> dout=0 for each; irq=0.
- Write PRESET=5, then CTRL=0x9 (one-shot, EN, IM) at edge E0 -> COUNT reads 5,4,3,2,1 on E2..E6; irq rises at E7 and stays high; CTRL reads 0x8; a write of CTRL=0x0 drops irq the next cycle.
- Write PRESET=3, then CTRL=0xB (auto-reload, EN, IM) -> irq is a single-cycle pulse every 6 cycles; COUNT cycles 3,2,1,0; CTRL stays 0xB.
- Start one-shot with PRESET=10, write CTRL=0x8 (EN=0) when COUNT=6 -> COUNT holds at 6 and no irq. Then write CTRL=0x9 -> COUNT reloads to 10 two edges later.
- Auto-reload with IM=0, PRESET=2 -> irq stays 0 throughout; an internal probe sees irq_flag pulsing. Writing PRESET=4 mid-count -> the current period is unchanged and the next period becomes 7 cycles.
- With TIMER_COUNT_WRITE_EN defined: running with PRESET=100, write COUNT=2 -> COUNT reads 1 at the next edge, then irq on the following edge. Without the macro: the same write leaves COUNT decrementing from its prior value.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with one-shot and auto-reload modes.
// Optional macro TIMER_COUNT_WRITE_EN makes COUNT (offset 2) writable from the bus.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    state_t           state;
    logic             en;
    logic             im;
    logic [1:0]       mode;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             irq_flag;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

`ifdef TIMER_COUNT_WRITE_EN
    logic wr_count;
    assign wr_count = we && (addr == ADDR_COUNT);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and the later bus writes below can
    // override the FSM's assignment to the same register in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            en       <= 1'b0;
            im       <= 1'b0;
            mode     <= 2'b00;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (en) state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (count > WIDTH'(1)) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (mode == MODE_AUTO) irq_flag <= 1'b0;
                    else                   en       <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // Bus writes come last so they win over the FSM in the same cycle.
            if (wr_ctrl) begin
                en       <= din[0];
                mode     <= din[2:1];
                im       <= din[3];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= din[WIDTH-1:0];
                irq_flag <= 1'b0;
            end
`ifdef TIMER_COUNT_WRITE_EN
            if (wr_count) count <= din[WIDTH-1:0];
`endif
        end
    end

    assign irq = im & irq_flag;

    // NOTE: dout gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, im, mode, en};
            ADDR_PRESET: dout = 32'(preset);
            ADDR_COUNT:  dout = 32'(count);
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register vector table, directed
// corner sequences and randomized runs against a timeline model.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    timer_counter #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Write lands on the next rising edge; returns at the following negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
    endtask

    // Timeline model: k edges after the enabling CTRL write (edge E0),
    // starting from reset values.
    task automatic model(input int n, input bit auto_mode, input bit im_bit, input int k,
                         output int exp_count, output bit exp_irq);
        int np;
        int p;
        int j;
        np = (n < 1) ? 1 : n;
        p  = np + 3;
        if (auto_mode) j = ((k - 1) % p) + 1;
        else           j = (k > np + 2) ? np + 2 : k;
        exp_count = (j >= 2 && j <= np + 1) ? n - (j - 2) : 0;
        if (auto_mode) exp_irq = im_bit && (j == np + 2);
        else           exp_irq = im_bit && (k >= np + 2);
    endtask

    task automatic run_trial(input int n, input logic [1:0] mode, input bit im_bit);
        int          np;
        int          exp_count;
        bit          exp_irq;
        bit          auto_mode;
        logic [31:0] exp_ctrl;
        auto_mode = (mode == 2'b01);
        np        = (n < 1) ? 1 : n;
        do_reset();
        bus_write(2'd1, 32'(n));
        bus_write(2'd0, {28'd0, im_bit, mode, 1'b1});
        addr = 2'd2;
        #1;
        for (int k = 1; k <= 2 * (np + 3) + 2; k++) begin
            tick();
            model(n, auto_mode, im_bit, k, exp_count, exp_irq);
            check($sformatf("trial n=%0d m=%0d k=%0d count", n, mode, k), dout, 32'(exp_count));
            check($sformatf("trial n=%0d m=%0d k=%0d irq", n, mode, k), {31'd0, irq}, {31'd0, exp_irq});
        end
        addr = 2'd0;
        #1;
        exp_ctrl = {28'd0, im_bit, mode, auto_mode};
        check($sformatf("trial n=%0d m=%0d ctrl", n, mode), dout, exp_ctrl);
    endtask

    initial begin
        int exp_flag;
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;
        @(negedge clk);
        do_reset();

        // Register access table; each row is checked before its write lands.
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b1, 2'd1, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 32'hFFFFFFF6, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h6,        1'b0};
        vecs[10] = '{1'b1, 2'd2, 32'h1234,     32'h0,        1'b0};
`ifdef TIMER_COUNT_WRITE_EN
        vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h1234,     1'b0};
`else
        vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
`endif
        vecs[12] = '{1'b1, 2'd0, 32'h0,        32'h6,        1'b0};
        vecs[13] = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b0};

        for (int i = 0; i < 14; i++) begin
            we   = vecs[i].we;
            addr = vecs[i].addr;
            din  = vecs[i].din;
            #1;
            check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            tick();
        end
        we = 1'b0;

        // One-shot, PRESET=5: COUNT 5..1 on E2..E6, irq from E7 held until a CTRL write.
        do_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        addr = 2'd2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("oneshot k=%0d count", k), dout, (k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0);
            check($sformatf("oneshot k=%0d irq", k), {31'd0, irq}, {31'd0, (k >= 7)});
        end
        addr = 2'd0;
        #1;
        check("oneshot ctrl after int", dout, 32'h8);
        bus_write(2'd0, 32'h0);
        check("oneshot irq cleared by ctrl write", {31'd0, irq}, 32'd0);

        // Clearing EN mid-count freezes COUNT; re-enable reloads from PRESET.
        do_reset();
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        addr = 2'd2;
        for (int k = 1; k <= 5; k++) tick();
        check("freeze pre count", dout, 32'd7);
        bus_write(2'd0, 32'h8);
        addr = 2'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("freeze hold %0d count", k), dout, 32'd6);
            check($sformatf("freeze hold %0d irq", k), {31'd0, irq}, 32'd0);
            tick();
        end
        bus_write(2'd0, 32'h9);
        addr = 2'd2;
        #1;
        check("reenable count +0", dout, 32'd6);
        tick();
        check("reenable count +1", dout, 32'd6);
        tick();
        check("reenable count +2", dout, 32'd10);

        // Auto-reload with IM=0: irq never rises, flag pulses; PRESET change mid-count.
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h3);
        addr = 2'd2;
        for (int k = 1; k <= 24; k++) begin
            if (k == 7) begin
                bus_write(2'd1, 32'd4);
                addr = 2'd2;
            end else begin
                tick();
            end
            exp_flag = (k == 4 || k == 9 || k == 16 || k == 23) ? 1 : 0;
            check($sformatf("noim k=%0d flag", k), {31'd0, dut.irq_flag}, 32'(exp_flag));
            check($sformatf("noim k=%0d irq", k), {31'd0, irq}, 32'd0);
        end

        // PRESET write on the edge the flag would be set: the write wins.
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) tick();
        bus_write(2'd1, 32'd3);
        check("preset wins irq E5", {31'd0, irq}, 32'd0);
        tick();
        check("preset wins irq E6", {31'd0, irq}, 32'd0);
        addr = 2'd0;
        #1;
        check("preset wins ctrl", dout, 32'h8);

        // CTRL write while in INT keeps EN and restarts the one-shot.
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) tick();
        check("ctrl in int irq E5", {31'd0, irq}, 32'd1);
        bus_write(2'd0, 32'h9);
        check("ctrl in int irq E6", {31'd0, irq}, 32'd0);
        check("ctrl in int ctrl E6", dout, 32'h9);
        addr = 2'd2;
        tick();
        tick();
        check("ctrl in int reload E8", dout, 32'd3);

        // COUNT write while running.
        do_reset();
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) tick();
        bus_write(2'd2, 32'd2);
`ifdef TIMER_COUNT_WRITE_EN
        check("count write E10", dout, 32'd2);
        tick();
        check("count write E11", dout, 32'd1);
        check("count write irq E11", {31'd0, irq}, 32'd0);
        tick();
        check("count write irq E12", {31'd0, irq}, 32'd1);
`else
        check("count ro E10", dout, 32'd92);
        tick();
        check("count ro E11", dout, 32'd91);
        tick();
        check("count ro E12", dout, 32'd90);
        check("count ro irq E12", {31'd0, irq}, 32'd0);
`endif

        // Model-checked runs: the documented auto-reload case, then random ones.
        run_trial(3, 2'b01, 1'b1);
        run_trial(0, 2'b00, 1'b1);
        for (int t = 0; t < 12; t++) begin
            run_trial(int'($urandom_range(0, 8)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
